// File: rtl/prog_mem_loader.sv
// prog_mem_loader: byte-stream loader for program memory (ORG / WR / END commands).
// Define PROG_LDR_VERIFY_EN to add a read-back VERIFY cycle after every write.
module prog_mem_loader #(
  parameter int DW = 18,
  parameter int AW = 12
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [7:0]    RX_D,
  input  logic          RX_VLD,
  output logic          RX_RDY,
  output logic [AW-1:0] A,
  output logic          WE,
  output logic [DW-1:0] DI,
  input  logic [DW-1:0] DQ,
  output logic          DONE,
  output logic          ERR
);
  localparam logic [7:0] CMD_ORG = 8'hA5;
  localparam logic [7:0] CMD_WR  = 8'h5A;
  localparam logic [7:0] CMD_END = 8'h0F;

  typedef enum logic [2:0] {
    CMD, ORG_H, ORG_L, WR_2, WR_1, WR_0, WRITE
`ifdef PROG_LDR_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          run_q, run_d;
  logic [AW-1:0] org_q, org_d;
  logic [7:0]    hi_q, hi_d;
  logic [DW-1:0] sr_q, sr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          xfer, busy, inc, vfail;

  assign xfer = RX_VLD && RX_RDY;

`ifdef PROG_LDR_VERIFY_EN
  assign inc   = (state_q == VERIFY);
  assign vfail = (state_q == VERIFY) && (DQ != DI);
`else
  logic dq_unused;
  assign dq_unused = ^DQ;
  assign inc       = (state_q == WRITE);
  assign vfail     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state_q <= CMD;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CMD:     if (xfer) state_d = (RX_D == CMD_ORG) ? ORG_H : (RX_D == CMD_WR) ? WR_2 : CMD;
      ORG_H:   if (xfer) state_d = ORG_L;
      ORG_L:   if (xfer) state_d = CMD;
      WR_2:    if (xfer) state_d = WR_1;
      WR_1:    if (xfer) state_d = WR_0;
      WR_0:    if (xfer) state_d = WRITE;
`ifdef PROG_LDR_VERIFY_EN
      WRITE:   state_d = VERIFY;
      VERIFY:  state_d = CMD;
`else
      WRITE:   state_d = CMD;
`endif
      default: state_d = CMD;
    endcase
  end

  always_comb begin
    busy = (state_q == WRITE);
`ifdef PROG_LDR_VERIFY_EN
    busy = busy || (state_q == VERIFY);
`endif
    RX_RDY = run_q && !busy;
    WE     = (state_q == WRITE);
  end

  assign A    = org_q;
  assign DI   = sr_q;
  assign DONE = done_q;
  assign ERR  = err_q || vfail;

  // Only the low DW bits of the 24-bit payload ever reach DI, so the shifter keeps just those.
  always_comb begin
    run_d  = 1'b1;
    org_d  = org_q;
    hi_d   = hi_q;
    sr_d   = sr_q;
    done_d = done_q;
    err_d  = err_q || vfail;
    if (xfer && state_q == CMD) begin
      done_d = (RX_D == CMD_END) || (done_q && RX_D != CMD_ORG && RX_D != CMD_WR);
      err_d  = err_q || !(RX_D inside {CMD_ORG, CMD_WR, CMD_END});
    end
    if (xfer && state_q == ORG_H) hi_d = RX_D;
    if (xfer && state_q == ORG_L) org_d = AW'({hi_q, RX_D});
    if (xfer && state_q inside {WR_2, WR_1, WR_0}) sr_d = {sr_q[DW-9:0], RX_D};
    if (inc) org_d = org_q + AW'(1);
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      run_q  <= 1'b0;
      org_q  <= '0;
      hi_q   <= '0;
      sr_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      run_q  <= run_d;
      org_q  <= org_d;
      hi_q   <= hi_d;
      sr_q   <= sr_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed and random load streams checked against a byte-level command model.
module tb_prog_mem_loader;
  localparam int DW = 18;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0, RSTN = 1'b0, RX_VLD = 1'b0;
  logic [7:0]    RX_D = 8'h00;
  logic          RX_RDY, WE, DONE, ERR;
  logic [AW-1:0] A;
  logic [DW-1:0] DI, DQ;
  logic [DW-1:0] mem [DEPTH];
  logic          bad_b0 = 1'b0;

  int n_tests = 0, n_fail = 0;
  int got_q[$], exp_q[$];
  int mph, morg, mhi, mword;
  logic mdone, merr;

  prog_mem_loader #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .RX_D(RX_D), .RX_VLD(RX_VLD), .RX_RDY(RX_RDY),
    .A(A), .WE(WE), .DI(DI), .DQ(DQ), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  assign DQ = mem[A] & ~DW'(bad_b0);
  always @(posedge CLK) if (WE) mem[A] <= DI;

  function automatic int wv(input int a, input int d);
    return (a << DW) | d;
  endfunction

  always @(negedge CLK) if (WE) got_q.push_back(wv(int'(A), int'(DI)));

  task automatic model_reset();
    mph = 0; morg = 0; mhi = 0; mword = 0; mdone = 1'b0; merr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_byte(input int b);
    case (mph)
      0: begin
        if (b == 'hA5 || b == 'h5A) begin mdone = 1'b0; mph = (b == 'hA5) ? 1 : 3; end
        else if (b == 'h0F) mdone = 1'b1;
        else merr = 1'b1;
      end
      1: begin mhi = b; mph = 2; end
      2: begin morg = ((mhi << 8) | b) % DEPTH; mph = 0; end
      3, 4: begin mword = ((mword << 8) | b) & 'hFFFFFF; mph++; end
      default: begin
        mword = ((mword << 8) | b) & 'hFFFFFF;
        exp_q.push_back(wv(morg, mword % (1 << DW)));
`ifdef PROG_LDR_VERIFY_EN
        if (bad_b0 && mword[0]) merr = 1'b1;
`endif
        morg = (morg + 1) % DEPTH;
        mph = 0;
      end
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge CLK);
    while (RX_RDY !== 1'b1 && k < 20) begin @(negedge CLK); k++; end
    if (k == 20) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout byte=%h rx_rdy=%b required 1", b, RX_RDY);
    end else begin
      RX_D = b; RX_VLD = 1'b1;
      @(posedge CLK);
      #1 RX_VLD = 1'b0; RX_D = 8'($urandom);
    end
  endtask

  task automatic push(input logic [7:0] b);
    model_byte(int'(b));
    send_byte(b);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    settle(2);
    n_tests++;
    if ({RX_RDY, WE, DONE, ERR} !== 4'b0 || A !== '0 || DI !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs rdy/we/done/err=%b A=%h DI=%h required all zero", {RX_RDY, WE, DONE, ERR}, A, DI);
    end
    RSTN = 1'b1; model_reset();
    #1 n_tests++;
    if (RX_RDY !== 1'b0) begin n_fail++; $display("FAIL rdy_before_edge got %b required 0", RX_RDY); end
    @(posedge CLK); #1 n_tests++;
    if (RX_RDY !== 1'b1) begin n_fail++; $display("FAIL rdy_first_edge got %b required 1", RX_RDY); end
  endtask

  task automatic test_basic();
    logic [7:0] s[$] = '{8'hA5, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h81, 8'h23};
    got_q.delete();
    foreach (s[i]) push(s[i]);
    settle(3);
    n_tests++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL basic_count got %0d required 1", got_q.size()); end
    else begin
      n_tests++;
      if (got_q[0] != wv('h000, 'h08123)) begin n_fail++; $display("FAIL basic_write got %h required %h", got_q[0], wv('h000, 'h08123)); end
    end
    n_tests++;
    if (A !== 12'h001) begin n_fail++; $display("FAIL basic_addr got %h required 001", A); end
  endtask

  task automatic test_wrap();
    logic [7:0] s[$] = '{8'hA5, 8'h0F, 8'hFF, 8'h5A, 8'h03, 8'hFF, 8'hFF, 8'h5A, 8'h00, 8'h00, 8'h01};
    got_q.delete();
    foreach (s[i]) push(s[i]);
    settle(3);
    n_tests++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL wrap_count got %0d required 2", got_q.size()); end
    else begin
      n_tests++;
      if (got_q[0] != wv('hFFF, 'h3FFFF)) begin n_fail++; $display("FAIL wrap_top got %h required %h", got_q[0], wv('hFFF, 'h3FFFF)); end
      n_tests++;
      if (got_q[1] != wv('h000, 'h00001)) begin n_fail++; $display("FAIL wrap_zero got %h required %h", got_q[1], wv('h000, 'h00001)); end
    end
    n_tests++;
    if (ERR !== 1'b0 || A !== 12'h001) begin n_fail++; $display("FAIL wrap_state err=%b A=%h required 0/001", ERR, A); end
  endtask

  task automatic test_done();
    got_q.delete();
    n_tests++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL done_idle got %b required 0", DONE); end
    push(8'h0F);
    n_tests++;
    if (DONE !== 1'b1) begin n_fail++; $display("FAIL done_set got %b required 1", DONE); end
    push(8'h5A);
    n_tests++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL done_clear got %b required 0", DONE); end
    push(8'h11); push(8'h22); push(8'h33);
    settle(3);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] != wv('h001, 'h12233)) begin
      n_fail++; $display("FAIL done_write count=%0d first=%h required 1/%h", got_q.size(), got_q.size() ? got_q[0] : 0, wv('h001, 'h12233));
    end
  endtask

  task automatic test_err();
    got_q.delete();
    push(8'h77);
    settle(2);
    n_tests++;
    if (ERR !== 1'b1 || got_q.size() != 0) begin n_fail++; $display("FAIL err_set err=%b writes=%0d required 1/0", ERR, got_q.size()); end
    push(8'hA5); push(8'h00); push(8'h10);
    settle(1);
    n_tests++;
    if (A !== 12'h010 || ERR !== 1'b1) begin n_fail++; $display("FAIL err_org A=%h err=%b required 010/1", A, ERR); end
    push(8'h0F);
    n_tests++;
    if (ERR !== 1'b1 || DONE !== 1'b1) begin n_fail++; $display("FAIL err_sticky err=%b done=%b required 1/1", ERR, DONE); end
  endtask

  task automatic test_latency();
    push(8'h5A); push(8'h2A); push(8'hBC); push(8'hDE);
    n_tests++;
    if (WE !== 1'b1 || RX_RDY !== 1'b0 || A !== 12'h010 || DI !== 18'h2BCDE) begin
      n_fail++; $display("FAIL lat_write we=%b rdy=%b A=%h DI=%h required 1/0/010/2bcde", WE, RX_RDY, A, DI);
    end
    @(posedge CLK); #1;
`ifdef PROG_LDR_VERIFY_EN
    n_tests++;
    if (WE !== 1'b0 || RX_RDY !== 1'b0 || A !== 12'h010) begin
      n_fail++; $display("FAIL lat_verify we=%b rdy=%b A=%h required 0/0/010", WE, RX_RDY, A);
    end
    @(posedge CLK); #1;
`endif
    n_tests++;
    if (WE !== 1'b0 || RX_RDY !== 1'b1 || A !== 12'h011) begin
      n_fail++; $display("FAIL lat_after we=%b rdy=%b A=%h required 0/1/011", WE, RX_RDY, A);
    end
  endtask

  task automatic test_abort();
    got_q.delete();
    push(8'h5A); push(8'h01); push(8'h02);
    #2 RSTN = 1'b0;
    #1 n_tests++;
    if (DI !== '0 || A !== '0 || ERR !== 1'b0 || DONE !== 1'b0 || RX_RDY !== 1'b0) begin
      n_fail++; $display("FAIL abort_async DI=%h A=%h err=%b done=%b rdy=%b required all zero", DI, A, ERR, DONE, RX_RDY);
    end
    settle(2);
    RSTN = 1'b1; model_reset();
    @(posedge CLK);
    push(8'h5A); push(8'h00); push(8'h00); push(8'h07);
    settle(3);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] != wv('h000, 'h00007) || A !== 12'h001) begin
      n_fail++; $display("FAIL abort_write count=%0d first=%h A=%h required 1/%h/001", got_q.size(), got_q.size() ? got_q[0] : 0, wv('h000, 'h00007), A);
    end
  endtask

  task automatic test_random(input int n, input bit bad);
    int r, v;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) settle($urandom_range(1, 2));
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        v = $urandom_range(0, 65535);
        push(8'hA5); push(8'(v >> 8)); push(8'(v));
      end else if (r == 2) begin
        v = ($urandom_range(0, 15) << 12) | 'h0FFC | $urandom_range(0, 3);
        push(8'hA5); push(8'(v >> 8)); push(8'(v));
      end else if (r == 7) push(8'h0F);
      else if (r == 8 && bad) begin
        v = $urandom_range(0, 255);
        while (v == 'hA5 || v == 'h5A || v == 'h0F) v = $urandom_range(0, 255);
        push(8'(v));
      end else begin
        push(8'h5A);
        for (int j = 0; j < 3; j++) push(8'($urandom));
      end
    end
    settle(4);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] != exp_q[i]) begin n_fail++; $display("FAIL rand_write[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++;
    if (int'(A) != morg || DONE !== mdone || ERR !== merr) begin
      n_fail++; $display("FAIL rand_state A=%h done=%b err=%b required %h/%b/%b", A, DONE, ERR, morg, mdone, merr);
    end
  endtask

`ifdef PROG_LDR_VERIFY_EN
  task automatic test_verify();
    RSTN = 1'b0; settle(2); RSTN = 1'b1; model_reset(); @(posedge CLK);
    bad_b0 = 1'b1;
    push(8'h5A); push(8'h00); push(8'h00); push(8'h01);
    @(posedge CLK); #1 n_tests++;
    if (ERR !== 1'b1 || A !== 12'h000) begin n_fail++; $display("FAIL verify_cycle err=%b A=%h required 1/000", ERR, A); end
    @(posedge CLK); #1 n_tests++;
    if (ERR !== 1'b1 || A !== 12'h001) begin n_fail++; $display("FAIL verify_after err=%b A=%h required 1/001", ERR, A); end
    bad_b0 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_done();
    test_err();
    test_latency();
    test_abort();
    test_random(40, 1'b0);
    test_random(40, 1'b1);
`ifdef PROG_LDR_VERIFY_EN
    test_verify();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
